// File: rtl/disp_chan_sched.sv
// Channel scheduler and CPU capture arbiter for the 8-channel display multiplexer.
// Optional build macro: DISP_CPU_PREEMPT_EN (a CPU capture in auto-scan jumps to channel 0).
module disp_chan_sched #(
  parameter int DWELL_W   = 24,
  parameter int DWELL_MIN = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         mode,
  input  logic [2:0]         sw_chan,
  input  logic               btn_step,
  input  logic [7:0]         chan_mask,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               cpu_wr_req,
  output logic [2:0]         Test,
  output logic               EN,
  output logic               cpu_wr_ack,
  output logic               chan_valid,
  output logic               chan_change,
  output logic [1:0]         dbg_wr_state
);

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_CAP  = 2'd1,
    WR_WAIT = 2'd2
  } wr_state_e;

  localparam logic [1:0] MODE_SW     = 2'b00;
  localparam logic [1:0] MODE_BTN    = 2'b01;
  localparam logic [1:0] MODE_AUTO   = 2'b10;
  localparam logic [DWELL_W-1:0] DWELL_MIN_L = DWELL_W'(DWELL_MIN);

  // Handshake: cpu_wr_req is a level request; cpu_wr_ack pulses once per request
  // and a new request is only accepted after req has been seen low for a cycle.

  logic [2:0]         test_q, test_d;
  logic               valid_q, valid_d;
  logic               change_q, change_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               btn_q, btn_d;
  wr_state_e          wr_q, wr_d;
  logic               en_q, en_d;
  logic               ack_q, ack_d;
  logic [DWELL_W-1:0] limit_m1;

  function automatic logic [2:0] next_en(input logic [2:0] c, input logic [7:0] m);
    logic [2:0] r;
    logic [2:0] idx;
    logic       found;
    r     = c;
    found = 1'b0;
    for (int i = 1; i < 8; i++) begin
      idx = c + 3'(i);
      if (!found && m[idx]) begin
        r     = idx;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  always_comb begin
    limit_m1 = ((dwell < DWELL_MIN_L) ? DWELL_MIN_L : dwell) - DWELL_W'(1);
  end

  always_comb begin
    test_d = test_q;
    cnt_d  = '0;
    btn_d  = btn_step;
    case (mode)
      MODE_SW: test_d = sw_chan;
      MODE_BTN: begin
        if (btn_step && !btn_q) test_d = next_en(test_q, chan_mask);
      end
      MODE_AUTO: begin
        // >= so a dwell shortened below the running count advances at once.
        if (cnt_q >= limit_m1) begin
          test_d = next_en(test_q, chan_mask);
        end else begin
          cnt_d = cnt_q + DWELL_W'(1);
        end
      end
      default: test_d = test_q;
    endcase
`ifdef DISP_CPU_PREEMPT_EN
    if (mode == MODE_AUTO && wr_q == WR_CAP) begin
      test_d = 3'd0;
      cnt_d  = '0;
    end
`endif
    valid_d  = chan_mask[test_d];
    change_d = (test_d != test_q);
  end

  always_comb begin
    wr_d  = wr_q;
    en_d  = 1'b0;
    ack_d = 1'b0;
    case (wr_q)
      WR_IDLE: begin
        if (cpu_wr_req) begin
          wr_d  = WR_CAP;
          en_d  = 1'b1;
          ack_d = 1'b1;
        end
      end
      WR_CAP:  wr_d = WR_WAIT;
      WR_WAIT: if (!cpu_wr_req) wr_d = WR_IDLE;
      default: wr_d = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      test_q   <= 3'd0;
      valid_q  <= 1'b0;
      change_q <= 1'b0;
      cnt_q    <= '0;
      btn_q    <= 1'b0;
      wr_q     <= WR_IDLE;
      en_q     <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      test_q   <= test_d;
      valid_q  <= valid_d;
      change_q <= change_d;
      cnt_q    <= cnt_d;
      btn_q    <= btn_d;
      wr_q     <= wr_d;
      en_q     <= en_d;
      ack_q    <= ack_d;
    end
  end

  assign Test         = test_q;
  assign chan_valid   = valid_q;
  assign chan_change  = change_q;
  assign EN           = en_q;
  assign cpu_wr_ack   = ack_q;
  assign dbg_wr_state = wr_q;

endmodule

// File: tb/tb_disp_chan_sched.sv
// Self-checking bench for disp_chan_sched: scheduling modes, write handshake, reset.
module tb_disp_chan_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic [2:0]  sw_chan;
  logic        btn_step;
  logic [7:0]  chan_mask;
  logic [23:0] dwell;
  logic        cpu_wr_req;
  logic [2:0]  Test;
  logic        EN;
  logic        cpu_wr_ack;
  logic        chan_valid;
  logic        chan_change;
  logic [1:0]  dbg_wr_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  disp_chan_sched #(.DWELL_W(24), .DWELL_MIN(16)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sw_chan(sw_chan), .btn_step(btn_step),
    .chan_mask(chan_mask), .dwell(dwell), .cpu_wr_req(cpu_wr_req),
    .Test(Test), .EN(EN), .cpu_wr_ack(cpu_wr_ack), .chan_valid(chan_valid),
    .chan_change(chan_change), .dbg_wr_state(dbg_wr_state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for channel advances: each entry is the next expected channel,
  // each expected exactly `interval` cycles after the previous one.
  task automatic run_scan(input int interval, input int max_cyc);
    int cyc = 0;
    int total = 0;
    logic [7:0] e;
    while (exp_q.size() > 0 && total < max_cyc) begin
      step();
      cyc++;
      total++;
      if (chan_change) begin
        e = exp_q.pop_front();
        n_tests++;
        if ({5'd0, Test} !== e || cyc !== interval) begin
          n_fail++;
          $display("FAIL scan_step: Test=%0d after %0d cycles, required %0d after %0d",
                   Test, cyc, e, interval);
        end
        cyc = 0;
      end
    end
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scan_timeout: %0d advances missing, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Scoreboard for capture pulses: each entry is the cycle number the pulse is due.
  task automatic watch_writes(input int ncyc);
    logic [7:0] e;
    for (int c = 1; c <= ncyc; c++) begin
      step();
      if (EN || cpu_wr_ack) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL wr_extra: EN=%0d ack=%0d at cycle %0d, required no pulse", EN, cpu_wr_ack, c);
        end else begin
          e = exp_q.pop_front();
          if (c !== int'(e) || EN !== 1'b1 || cpu_wr_ack !== 1'b1 || dbg_wr_state !== 2'd1) begin
            n_fail++;
            $display("FAIL wr_pulse: cycle=%0d EN=%0d ack=%0d st=%0d, required cycle=%0d EN=1 ack=1 st=1",
                     c, EN, cpu_wr_ack, dbg_wr_state, e);
          end
        end
      end
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL wr_missing: %0d pulses missing, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    #1;
    n_tests++;
    if (Test !== 3'd0 || EN !== 1'b0 || cpu_wr_ack !== 1'b0 || chan_change !== 1'b0 ||
        chan_valid !== 1'b0 || dbg_wr_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: Test=%0d EN=%0d ack=%0d chg=%0d vld=%0d st=%0d, required all 0",
               Test, EN, cpu_wr_ack, chan_change, chan_valid, dbg_wr_state);
    end
    #12 rst = 1'b1;
    step();
    n_tests++;
    if (Test !== 3'd5 || chan_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_sel: Test=%0d vld=%0d, required 5 1", Test, chan_valid);
    end
    cpu_wr_req = 1'b1;
    step();
    n_tests++;
    if (EN !== 1'b1 || cpu_wr_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_cap_setup: EN=%0d ack=%0d, required 1 1", EN, cpu_wr_ack);
    end
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if (Test !== 3'd0 || EN !== 1'b0 || cpu_wr_ack !== 1'b0 || dbg_wr_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_async: Test=%0d EN=%0d ack=%0d st=%0d, required 0 0 0 0",
               Test, EN, cpu_wr_ack, dbg_wr_state);
    end
    cpu_wr_req = 1'b0;
    sw_chan = 3'd6;
    #2 rst = 1'b1;
    step();
    n_tests++;
    if (Test !== 3'd6 || chan_change !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_sel: Test=%0d chg=%0d, required 6 1", Test, chan_change);
    end
    step();
    n_tests++;
    if (Test !== 3'd6 || chan_change !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_change_once: Test=%0d chg=%0d, required 6 0", Test, chan_change);
    end
  endtask

  task automatic test_auto_scan();
    int changes = 0;
    chan_mask = 8'b1010_0101;
    mode = 2'b00;
    sw_chan = 3'd0;
    step();
    mode = 2'b10;
    dwell = 24'd20;
    exp_q.push_back(8'd2);
    exp_q.push_back(8'd5);
    exp_q.push_back(8'd7);
    exp_q.push_back(8'd0);
    run_scan(20, 200);
    n_tests++;
    if (chan_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL scan_valid: vld=%0d, required 1", chan_valid);
    end
    chan_mask = 8'h00;
    for (int i = 0; i < 60; i++) begin
      step();
      if (chan_change) changes++;
    end
    n_tests++;
    if (Test !== 3'd0 || chan_valid !== 1'b0 || changes !== 0) begin
      n_fail++;
      $display("FAIL scan_mask_zero: Test=%0d vld=%0d changes=%0d, required 0 0 0",
               Test, chan_valid, changes);
    end
    chan_mask = 8'hFF;
    mode = 2'b01;
    step();
    mode = 2'b10;
    dwell = 24'd3;
    exp_q.push_back(8'd1);
    exp_q.push_back(8'd2);
    run_scan(16, 100);
  endtask

  task automatic test_button();
    int changes = 0;
    chan_mask = 8'hFF;
    mode = 2'b00;
    sw_chan = 3'd7;
    step();
    mode = 2'b01;
    btn_step = 1'b0;
    step();
    btn_step = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      if (chan_change) changes++;
    end
    n_tests++;
    if (Test !== 3'd0 || changes !== 1) begin
      n_fail++;
      $display("FAIL btn_wrap: Test=%0d changes=%0d, required 0 1", Test, changes);
    end
    btn_step = 1'b0;
    chan_mask = 8'b0000_1000;
    mode = 2'b00;
    sw_chan = 3'd3;
    step();
    mode = 2'b01;
    step();
    btn_step = 1'b1;
    changes = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (chan_change) changes++;
    end
    n_tests++;
    if (Test !== 3'd3 || changes !== 0 || chan_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL btn_single: Test=%0d changes=%0d vld=%0d, required 3 0 1",
               Test, changes, chan_valid);
    end
    btn_step = 1'b0;
    chan_mask = 8'hFF;
  endtask

  task automatic test_write();
    mode = 2'b11;
    cpu_wr_req = 1'b1;
    exp_q.push_back(8'd1);
    watch_writes(10);
    cpu_wr_req = 1'b0;
    step();
    cpu_wr_req = 1'b1;
    exp_q.push_back(8'd1);
    watch_writes(5);
    cpu_wr_req = 1'b0;
    #3 cpu_wr_req = 1'b1;
    watch_writes(5);
    cpu_wr_req = 1'b0;
    step();
  endtask

  task automatic test_simultaneous();
    chan_mask = 8'hFF;
    mode = 2'b00;
    sw_chan = 3'd3;
    step();
    mode = 2'b10;
    dwell = 24'd20;
    for (int i = 0; i < 19; i++) step();
    cpu_wr_req = 1'b1;
    step();
    n_tests++;
    if (EN !== 1'b1 || Test !== 3'd4 || chan_change !== 1'b1) begin
      n_fail++;
      $display("FAIL sim_same_edge: EN=%0d Test=%0d chg=%0d, required 1 4 1", EN, Test, chan_change);
    end
    cpu_wr_req = 1'b0;
    step();
`ifdef DISP_CPU_PREEMPT_EN
    n_tests++;
    if (Test !== 3'd0 || chan_change !== 1'b1) begin
      n_fail++;
      $display("FAIL sim_preempt: Test=%0d chg=%0d, required 0 1", Test, chan_change);
    end
    exp_q.push_back(8'd1);
    run_scan(20, 60);
`else
    n_tests++;
    if (Test !== 3'd4 || chan_change !== 1'b0) begin
      n_fail++;
      $display("FAIL sim_no_preempt: Test=%0d chg=%0d, required 4 0", Test, chan_change);
    end
    exp_q.push_back(8'd5);
    run_scan(19, 60);
`endif
  endtask

  task automatic test_mode_switch();
    int changes = 0;
    chan_mask = 8'hFF;
    mode = 2'b00;
    sw_chan = 3'd1;
    step();
    mode = 2'b10;
    dwell = 24'd20;
    for (int i = 0; i < 10; i++) step();
    mode = 2'b11;
    for (int i = 0; i < 5; i++) begin
      step();
      if (chan_change) changes++;
    end
    n_tests++;
    if (Test !== 3'd1 || changes !== 0) begin
      n_fail++;
      $display("FAIL freeze_hold: Test=%0d changes=%0d, required 1 0", Test, changes);
    end
    mode = 2'b10;
    exp_q.push_back(8'd2);
    run_scan(20, 60);
    mode = 2'b00;
    sw_chan = 3'd2;
    btn_step = 1'b1;
    for (int i = 0; i < 3; i++) step();
    mode = 2'b01;
    changes = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (chan_change) changes++;
    end
    n_tests++;
    if (Test !== 3'd2 || changes !== 0) begin
      n_fail++;
      $display("FAIL btn_held_entry: Test=%0d changes=%0d, required 2 0", Test, changes);
    end
    btn_step = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    mode = 2'b00;
    sw_chan = 3'd5;
    btn_step = 1'b0;
    chan_mask = 8'hFF;
    dwell = 24'd20;
    cpu_wr_req = 1'b0;
    test_reset();
    test_auto_scan();
    test_button();
    test_write();
    test_simultaneous();
    test_mode_switch();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
